mesh_loader: RTL and testbench
==============================

Name: mesh_loader

Overview:
- Upstream stage of the subdivision pipeline.
- Accepts a streamed mesh (header, then vertices, then faces) over a valid/ready word interface and writes it into the object RAM.
- Produces the vertex_count / face_count values that the neighbour and averager stages consume.
- Signals done so the top-level controller can start the neighbour stage.

Parameters:
- ADDR_W, 9, object RAM address width.
- RAM_DEPTH, 512, object RAM depth in 32-bit words.
- WORDS_PER_VERTEX, 3, words per vertex (x, y, z).
- WORDS_PER_FACE, 3, words per face (three vertex indices).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a new load; honoured only in IDLE, DONE or ERR.
- s_data  in  32  stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a word.
- ram_en  out  1  object RAM enable.
- ram_a  out  ADDR_W  object RAM word address.
- ram_we  out  4  object RAM byte write enables.
- ram_di  out  32  object RAM write data.
- vertex_count  out  32  loaded vertex count.
- face_count  out  32  loaded face count.
- busy  out  1  load in progress.
- done  out  1  load completed successfully (level).
- error  out  1  load aborted (level).

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). All state is updated on the posedge of clk.
- Reset values: s_ready=0, ram_en=0, ram_a=0, ram_we=0, ram_di=0, vertex_count=0, face_count=0, busy=0, done=0, error=0; FSM in IDLE.
- Transfer rule: a word transfers on a clock edge where s_valid && s_ready.
- s_ready is registered. It is 1 in HDR_V, HDR_F, VERTS and FACES, and 0 in all other states.
- FSM states: IDLE, HDR_V, HDR_F, CHECK, VERTS, FACES, DONE, ERR.
- IDLE/DONE/ERR --start--> HDR_V:
  - clears done and error;
  - sets busy=1;
  - zeroes the address counter.
- HDR_V: on transfer, latch vertex_count=s_data; go to HDR_F.
- HDR_F: on transfer, latch face_count=s_data; go to CHECK.
- CHECK (one cycle, s_ready=0):
  - total = WORDS_PER_VERTEX*V + WORDS_PER_FACE*F, computed at 35 bits so it cannot overflow;
  - if V==0, F==0 or total>RAM_DEPTH, go to ERR;
  - otherwise go to VERTS.
- VERTS: each transfer writes one word at the address counter, then increments the counter. After word WORDS_PER_VERTEX*V-1 is written, go to FACES.
- FACES: same write behaviour as VERTS. After the last word (address total-1), go to DONE.
- Write timing: 1-cycle latency. The cycle after a transfer drives ram_en=1, ram_we=4'hF, ram_a=counter value, ram_di=word. In every other cycle ram_en=0 and ram_we=0.
- DONE:
  - busy=0, done=1;
  - vertex_count and face_count are held until the next start.
  - The last RAM write completes in the same cycle that done rises.
- ERR: busy=0, error=1, s_ready=0. Stays in ERR until start or rst.
- start while busy is ignored.
- Stalls (s_valid=0) insert no RAM write and do not advance the counter.
- The address never exceeds total-1 <= RAM_DEPTH-1, so no wrap-around can occur.
- rst mid-load:
  - returns to IDLE next edge;
  - any pending RAM write is dropped (ram_en=0);
  - RAM contents already written are left untouched.

Optional Feature:
- Macro: MESH_LOADER_IDX_CHECK_EN.
- When defined: in FACES, a transferred word >= vertex_count is not written. The FSM goes to ERR on that edge and the counter is not advanced.
- When undefined: face words are written unchecked.

Test Plan:
- Icosahedron load (V=12, F=20, 96 payload words, s_valid held high) -> 96 writes at addresses 0..95, vertex_count=12, face_count=20, done=1 one cycle after the last transfer, error=0.
- Capacity boundary:
  - V=100, F=70 (total 510) -> loads, last ram_a=509, done=1.
  - V=86, F=85 (total 513) -> ERR after CHECK, zero RAM writes, s_ready=0.
- Backpressure: random s_valid with ~50% duty on the icosahedron mesh -> identical RAM contents and address sequence to the back-to-back case, no duplicate or skipped addresses.
- Zero counts: V=0, F=20 -> error=1, no writes; then start and a valid mesh -> error cleared and a normal load completes.
- Reset mid-load: assert rst after 40 payload words -> next cycle all outputs at reset values; a subsequent start reloads from address 0.
- With MESH_LOADER_IDX_CHECK_EN defined: the first face word is 12 with V=12 -> ERR with no write at address 36. Without the macro defined, the same stimulus writes 12 to address 36 and done=1.

Source files
------------

// File: rtl/mesh_loader.sv
// Streams a mesh (header, vertices, faces) into the object RAM and publishes its counts.
// Optional build macro MESH_LOADER_IDX_CHECK_EN rejects face indices >= vertex_count.
module mesh_loader #(
    parameter int ADDR_W           = 9,
    parameter int RAM_DEPTH        = 512,
    parameter int WORDS_PER_VERTEX = 3,
    parameter int WORDS_PER_FACE   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_a,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_di,
    output logic [31:0]       vertex_count,
    output logic [31:0]       face_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_V,
        HDR_F,
        CHECK,
        VERTS,
        FACES,
        DONE,
        ERR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              s_ready_q;
    logic              ram_en_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [3:0]        ram_we_q;
    logic [31:0]       ram_di_q;
    logic [31:0]       vertex_count_q;
    logic [31:0]       face_count_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic [34:0]       vert_words_d;
    logic [34:0]       total_d;
    logic [34:0]       next_cnt_d;
    logic              xfer_d;
    logic              idx_bad_d;

    // Counts are stable from CHECK until the next start, so the word totals stay valid all load long.
    always_comb begin
        vert_words_d = 35'(WORDS_PER_VERTEX) * {3'b0, vertex_count_q};
        total_d      = vert_words_d + 35'(WORDS_PER_FACE) * {3'b0, face_count_q};
        next_cnt_d   = 35'(cnt_q) + 35'd1;
        xfer_d       = s_valid && s_ready_q;
    end

`ifdef MESH_LOADER_IDX_CHECK_EN
    assign idx_bad_d = (s_data >= vertex_count_q);
`else
    assign idx_bad_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            s_ready_q      <= 1'b0;
            ram_en_q       <= 1'b0;
            ram_a_q        <= '0;
            ram_we_q       <= 4'h0;
            ram_di_q       <= '0;
            vertex_count_q <= '0;
            face_count_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            // NOTE: default non-blocking assignments first; a later one in the same block wins, so writes are one-cycle pulses.
            ram_en_q <= 1'b0;
            ram_we_q <= 4'h0;

            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q   <= HDR_V;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                    end
                end
                HDR_V: begin
                    if (xfer_d) begin
                        vertex_count_q <= s_data;
                        state_q        <= HDR_F;
                    end
                end
                HDR_F: begin
                    if (xfer_d) begin
                        face_count_q <= s_data;
                        state_q      <= CHECK;
                        s_ready_q    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (vertex_count_q == '0 || face_count_q == '0 ||
                        total_d > 35'(RAM_DEPTH)) begin
                        state_q <= ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        state_q   <= VERTS;
                        s_ready_q <= 1'b1;
                    end
                end
                VERTS, FACES: begin
                    if (xfer_d) begin
                        if (state_q == FACES && idx_bad_d) begin
                            state_q   <= ERR;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                            error_q   <= 1'b1;
                        end else begin
                            ram_en_q <= 1'b1;
                            ram_we_q <= 4'hF;
                            ram_a_q  <= cnt_q;
                            ram_di_q <= s_data;
                            cnt_q    <= cnt_q + 1'b1;
                            if (state_q == VERTS && next_cnt_d == vert_words_d) begin
                                state_q <= FACES;
                            end
                            if (state_q == FACES && next_cnt_d == total_d) begin
                                state_q   <= DONE;
                                s_ready_q <= 1'b0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign ram_en       = ram_en_q;
    assign ram_a        = ram_a_q;
    assign ram_we       = ram_we_q;
    assign ram_di       = ram_di_q;
    assign vertex_count = vertex_count_q;
    assign face_count   = face_count_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_mesh_loader.sv
// Randomized bench for mesh_loader: streams meshes and compares captured RAM writes to a stream-level model.
// Honours MESH_LOADER_IDX_CHECK_EN the same way the design does.
module tb_mesh_loader;

    localparam int ADDR_W    = 9;
    localparam int RAM_DEPTH = 512;
    localparam int BUDGET    = 5000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_a;
    logic [3:0]        ram_we;
    logic [31:0]       ram_di;
    logic [31:0]       vertex_count;
    logic [31:0]       face_count;
    logic              busy;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]       stream[$];
    logic [ADDR_W-1:0] wr_a[$];
    logic [31:0]       wr_d[$];

    mesh_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ram_en       (ram_en),
        .ram_a        (ram_a),
        .ram_we       (ram_we),
        .ram_di       (ram_di),
        .vertex_count (vertex_count),
        .face_count   (face_count),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every cycle the byte enables must match the enable.
    always @(negedge clk) begin
        check("ram_we_vs_en", {60'd0, ram_we}, ram_en ? 64'hF : 64'h0);
        if (ram_en) begin
            wr_a.push_back(ram_a);
            wr_d.push_back(ram_di);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_ram_en"}, ram_en, 0);
        check({tag, "_ram_a"}, ram_a, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_di"}, ram_di, 0);
        check({tag, "_vcount"}, vertex_count, 0);
        check({tag, "_fcount"}, face_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic build_mesh(input int v, input int f, input bit bad_first_face);
        stream.delete();
        stream.push_back(32'(v));
        stream.push_back(32'(f));
        for (int i = 0; i < 3 * v; i++) stream.push_back($urandom);
        for (int i = 0; i < 3 * f; i++)
            stream.push_back((v > 0) ? $urandom_range(0, v - 1) : 32'd0);
        if (bad_first_face && f > 0) stream[2 + 3 * v] = 32'(v);
    endtask

    // Reference: how many payload words should land in RAM, and whether the load should abort.
    task automatic model(input int v, input int f, output int n_wr, output bit err);
        longint tot;
        tot = 3 * longint'(v) + 3 * longint'(f);
        if (v == 0 || f == 0 || tot > RAM_DEPTH) begin
            n_wr = 0;
            err  = 1'b1;
        end else begin
            n_wr = int'(tot);
            err  = 1'b0;
`ifdef MESH_LOADER_IDX_CHECK_EN
            for (int i = 3 * v; i < int'(tot); i++) begin
                if (stream[2 + i] >= 32'(v)) begin
                    n_wr = i;
                    err  = 1'b1;
                    break;
                end
            end
`endif
        end
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_ready"}, s_ready, 1);
        check({tag, "_start_done"}, done, 0);
        check({tag, "_start_error"}, error, 0);
    endtask

    // Streams stream[0..limit-1]; returns on a negedge after the final transfer or once error is seen.
    task automatic drive(input string tag, input int limit, input bit rnd, input bit chk_done);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit xfer;
        forever begin
            @(negedge clk);
            if (idx >= limit || error || cyc >= BUDGET) break;
            v       = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_valid = v;
            s_data  = stream[idx];
            xfer    = v && s_ready;
            if (xfer && idx == limit - 1 && chk_done) check({tag, "_done_early"}, done, 0);
            @(posedge clk);
            if (xfer) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        if (cyc >= BUDGET) check({tag, "_timeout"}, 64'(idx), 64'(limit));
    endtask

    task automatic compare_writes(input string tag, input int n);
        check({tag, "_nwrites"}, 64'(wr_a.size()), 64'(n));
        for (int i = 0; i < n && i < wr_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_a[i], 64'(i));
            check($sformatf("%s_data%0d", tag, i), wr_d[i], stream[2 + i]);
        end
    endtask

    task automatic run_mesh(input string tag, input int v, input int f, input bit rnd,
                            input bit bad_first_face);
        int n_wr;
        bit err;
        build_mesh(v, f, bad_first_face);
        model(v, f, n_wr, err);
        wr_a.delete();
        wr_d.delete();
        pulse_start(tag);
        drive(tag, stream.size(), rnd, !err);
        check({tag, "_done"}, done, !err);
        check({tag, "_error"}, error, err);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        if (!err) check({tag, "_last_wr_now"}, ram_en, 1);
        @(posedge clk);
        #1;
        compare_writes(tag, n_wr);
        check({tag, "_vcount"}, vertex_count, 64'(v));
        check({tag, "_fcount"}, face_count, 64'(f));
        if (!err && wr_a.size() > 0) check({tag, "_last_addr"}, wr_a[wr_a.size() - 1], 64'(n_wr - 1));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_mesh("ico", 12, 20, 1'b0, 1'b0);
        run_mesh("ico_bp", 12, 20, 1'b1, 1'b0);
        run_mesh("cap510", 100, 70, 1'b0, 1'b0);
        run_mesh("cap513", 86, 85, 1'b0, 1'b0);
        run_mesh("zero_v", 0, 20, 1'b0, 1'b0);
        run_mesh("after_err", 12, 20, 1'b1, 1'b0);

        // Reset after 40 payload words, then a full reload must restart at address 0.
        build_mesh(12, 20, 1'b0);
        wr_a.delete();
        wr_d.delete();
        pulse_start("rst_mid");
        drive("rst_mid", 2 + 40, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_mid");
        compare_writes("rst_mid", 40);
        @(negedge clk);
        rst = 1'b0;
        run_mesh("reload", 12, 20, 1'b1, 1'b0);

        run_mesh("idx12", 12, 20, 1'b0, 1'b1);
`ifndef MESH_LOADER_IDX_CHECK_EN
        if (wr_d.size() > 36) check("idx12_word36", wr_d[36], 64'd12);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
